// File: rtl/usb_tg_pkg.sv
// rtl/usb_tg_pkg.sv - shared types, constants and byte-pattern helpers for the USB AXIS traffic generator
package usb_tg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } tg_state_t;

  localparam int DEF_TDATA_WIDTH = 4;
  localparam int DEF_GAP_CYCLES  = 16;

  // Byte i of packet p carries (p + i) mod 256
  function automatic logic [7:0] pattern_byte(input logic [7:0] pkt, input logic [7:0] idx);
    return pkt + idx;
  endfunction

  // Lane mask with the low n bits set (n >= 64 gives all ones)
  function automatic logic [63:0] keep_from_rem(input logic [16:0] n);
    logic [63:0] m;
    m = '0;
    for (int j = 0; j < 64; j++) begin
      m[j] = (17'(j) < n);
    end
    return m;
  endfunction

endpackage

// File: rtl/usb_axis_checker.sv
// rtl/usb_axis_checker.sv - receive-side packet checker with rx/error counters and sticky error flag
module usb_axis_checker
  import usb_tg_pkg::*;
#(
  parameter int TDATA_WIDTH = DEF_TDATA_WIDTH,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     clr,
  input  logic [15:0]              pkt_len,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic [8*TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic [TDATA_WIDTH-1:0]   s_axis_tkeep,
  input  logic [TDATA_WIDTH-1:0]   s_axis_tstrb,
  input  logic                     s_axis_tlast,
  output logic [CNT_WIDTH-1:0]     rx_pkt_cnt,
  output logic [CNT_WIDTH-1:0]     err_cnt,
  output logic                     err_flag
);

  logic [7:0]  exp_pkt;
  logic [15:0] exp_off;
  logic [6:0]  n_kept;
  logic [7:0]  n_err;
  logic        hole;
  logic        seen;
  logic        len_bad;
  logic        resync;
  logic [16:0] total;
  logic [CNT_WIDTH:0] err_sum;
  logic        hs;
  logic        unused_strb;

  assign unused_strb = ^s_axis_tstrb;
  assign hs = s_axis_tvalid && s_axis_tready;

  // Score one beat: lane mismatches, tkeep holes and packet-length violations
  always_comb begin
    n_kept = '0;
    n_err  = '0;
    hole   = 1'b0;
    seen   = 1'b0;
    for (int j = TDATA_WIDTH - 1; j >= 0; j--) begin
      if (s_axis_tkeep[j]) begin
        seen   = 1'b1;
        n_kept = n_kept + 7'd1;
        if (s_axis_tdata[8*j +: 8] != pattern_byte(exp_pkt, exp_off[7:0] + 8'(j))) begin
          n_err = n_err + 8'd1;
        end
      end else if (seen) begin
        hole = 1'b1;
      end
    end
    total   = {1'b0, exp_off} + 17'(n_kept);
    len_bad = s_axis_tlast ? (total != {1'b0, pkt_len}) : (total >= {1'b0, pkt_len});
    resync  = s_axis_tlast || len_bad;
    n_err   = n_err + 8'(hole) + 8'(len_bad);
    err_sum = {1'b0, err_cnt} + (CNT_WIDTH + 1)'(n_err);
  end

  // Track expected packet/byte position and update counters on each handshake
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s_axis_tready <= 1'b0;
      exp_pkt       <= '0;
      exp_off       <= '0;
      rx_pkt_cnt    <= '0;
      err_cnt       <= '0;
      err_flag      <= 1'b0;
    end else begin
      s_axis_tready <= 1'b1;
      if (clr) begin
        exp_pkt    <= '0;
        exp_off    <= '0;
        rx_pkt_cnt <= '0;
        err_cnt    <= '0;
        err_flag   <= 1'b0;
      end else if (hs) begin
        if (resync) begin
          exp_pkt <= exp_pkt + 8'd1;
          exp_off <= '0;
        end else begin
          exp_off <= total[15:0];
        end
        if (s_axis_tlast) begin
          rx_pkt_cnt <= rx_pkt_cnt + CNT_WIDTH'(1);
        end
        if (n_err != 8'd0) begin
          err_flag <= 1'b1;
          err_cnt  <= err_sum[CNT_WIDTH] ? '1 : err_sum[CNT_WIDTH-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/usb_axis_traffic_gen.sv
// rtl/usb_axis_traffic_gen.sv - AXIS packet generator and checker top; optional USB_TG_LATENCY_EN adds lat_cycles
module usb_axis_traffic_gen
  import usb_tg_pkg::*;
#(
  parameter int TDATA_WIDTH = DEF_TDATA_WIDTH,
  parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     start,
  input  logic                     stop,
  input  logic [15:0]              pkt_len,
  input  logic [15:0]              pkt_num,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [8*TDATA_WIDTH-1:0] m_axis_tdata,
  output logic [TDATA_WIDTH-1:0]   m_axis_tkeep,
  output logic [TDATA_WIDTH-1:0]   m_axis_tstrb,
  output logic                     m_axis_tlast,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic [8*TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic [TDATA_WIDTH-1:0]   s_axis_tkeep,
  input  logic [TDATA_WIDTH-1:0]   s_axis_tstrb,
  input  logic                     s_axis_tlast,
  output logic                     busy,
  output logic [CNT_WIDTH-1:0]     tx_pkt_cnt,
  output logic [CNT_WIDTH-1:0]     rx_pkt_cnt,
  output logic [CNT_WIDTH-1:0]     err_cnt,
  output logic                     err_flag
`ifdef USB_TG_LATENCY_EN
  ,
  output logic [CNT_WIDTH-1:0]     lat_cycles
`endif
);

  localparam logic [16:0] W17 = 17'(TDATA_WIDTH);

  tg_state_t state;
  logic [15:0] len_q, num_q, pkt_idx, byte_off, gap_cnt;
  logic        stop_q;
  logic [15:0] len_eff, ld_pkt, ld_off, ld_len;
  logic [16:0] ld_rem;
  logic        ld_last;
  logic [TDATA_WIDTH-1:0]   ld_keep;
  logic [8*TDATA_WIDTH-1:0] ld_data;
  logic        clr;

  assign len_eff      = (pkt_len == 16'd0) ? 16'd1 : pkt_len;
  assign clr          = start && (state == ST_IDLE);
  assign busy         = (state != ST_IDLE);
  assign m_axis_tstrb = m_axis_tkeep;

  // Build the next beat to present: start of run, next beat, or start of next packet
  always_comb begin
    ld_pkt  = pkt_idx;
    ld_off  = byte_off + 16'(TDATA_WIDTH);
    ld_len  = len_q;
    ld_data = '0;
    if (state == ST_IDLE) begin
      ld_pkt = '0;
      ld_off = '0;
      ld_len = len_eff;
    end else if (state == ST_GAP) begin
      ld_off = '0;
    end else if (m_axis_tlast) begin
      ld_pkt = pkt_idx + 16'd1;
      ld_off = '0;
    end
    ld_rem  = {1'b0, ld_len} - {1'b0, ld_off};
    ld_last = (ld_rem <= W17);
    ld_keep = ld_last ? TDATA_WIDTH'(keep_from_rem(ld_rem)) : '1;
    for (int j = 0; j < TDATA_WIDTH; j++) begin
      ld_data[8*j +: 8] = ld_keep[j] ? pattern_byte(ld_pkt[7:0], ld_off[7:0] + 8'(j)) : 8'h00;
    end
  end

  // Generator FSM with registered stream outputs and tx packet counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= ST_IDLE;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
      len_q         <= '0;
      num_q         <= '0;
      pkt_idx       <= '0;
      byte_off      <= '0;
      gap_cnt       <= '0;
      stop_q        <= 1'b0;
      tx_pkt_cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          stop_q <= 1'b0;
          if (start) begin
            state         <= ST_SEND;
            len_q         <= len_eff;
            num_q         <= pkt_num;
            tx_pkt_cnt    <= '0;
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= ld_data;
            m_axis_tkeep  <= ld_keep;
            m_axis_tlast  <= ld_last;
            pkt_idx       <= ld_pkt;
            byte_off      <= ld_off;
          end
        end
        ST_SEND: begin
          if (stop) stop_q <= 1'b1;
          if (m_axis_tvalid && m_axis_tready) begin
            if (!m_axis_tlast) begin
              m_axis_tdata <= ld_data;
              m_axis_tkeep <= ld_keep;
              m_axis_tlast <= ld_last;
              byte_off     <= ld_off;
            end else begin
              tx_pkt_cnt <= tx_pkt_cnt + CNT_WIDTH'(1);
              pkt_idx    <= ld_pkt;
              byte_off   <= '0;
              if (stop_q || stop || ((num_q != 16'd0) && (ld_pkt == num_q))) begin
                state         <= ST_IDLE;
                m_axis_tvalid <= 1'b0;
                m_axis_tdata  <= '0;
                m_axis_tkeep  <= '0;
                m_axis_tlast  <= 1'b0;
              end else if (GAP_CYCLES == 0) begin
                m_axis_tdata <= ld_data;
                m_axis_tkeep <= ld_keep;
                m_axis_tlast <= ld_last;
              end else begin
                state         <= ST_GAP;
                m_axis_tvalid <= 1'b0;
                m_axis_tdata  <= '0;
                m_axis_tkeep  <= '0;
                m_axis_tlast  <= 1'b0;
                gap_cnt       <= 16'(GAP_CYCLES - 1);
              end
            end
          end
        end
        ST_GAP: begin
          if (stop) stop_q <= 1'b1;
          if (gap_cnt == 16'd0) begin
            state         <= ST_SEND;
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= ld_data;
            m_axis_tkeep  <= ld_keep;
            m_axis_tlast  <= ld_last;
            byte_off      <= ld_off;
          end else begin
            gap_cnt <= gap_cnt - 16'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  usb_axis_checker #(
    .TDATA_WIDTH (TDATA_WIDTH),
    .CNT_WIDTH   (CNT_WIDTH)
  ) u_checker (
    .clk           (clk),
    .rstn          (rstn),
    .clr           (clr),
    .pkt_len       (len_q),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tstrb  (s_axis_tstrb),
    .s_axis_tlast  (s_axis_tlast),
    .rx_pkt_cnt    (rx_pkt_cnt),
    .err_cnt       (err_cnt),
    .err_flag      (err_flag)
  );

`ifdef USB_TG_LATENCY_EN
  logic lat_run, lat_done, first_tx, rx_hs;

  assign first_tx = (state == ST_SEND) && m_axis_tvalid && m_axis_tready &&
                    (pkt_idx == 16'd0) && (byte_off == 16'd0);
  assign rx_hs    = s_axis_tvalid && s_axis_tready;

  // Round-trip timer from first transmit beat of the run to first received beat
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lat_cycles <= '0;
      lat_run    <= 1'b0;
      lat_done   <= 1'b0;
    end else if (clr) begin
      lat_cycles <= '0;
      lat_run    <= 1'b0;
      lat_done   <= 1'b0;
    end else if (!lat_done) begin
      if (lat_run && (lat_cycles != '1)) lat_cycles <= lat_cycles + CNT_WIDTH'(1);
      if ((lat_run || first_tx) && rx_hs) begin
        lat_done <= 1'b1;
        lat_run  <= 1'b0;
      end else if (first_tx) begin
        lat_run <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_usb_axis_traffic_gen.sv
// tb/tb_usb_axis_traffic_gen.sv - randomized self-checking bench for usb_axis_traffic_gen
module tb_usb_axis_traffic_gen;

  localparam int W   = 4;
  localparam int GAP = 16;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn, start, stop;
  logic [15:0] pkt_len, pkt_num;
  logic        m_tvalid, m_tready, m_tlast;
  logic [31:0] m_tdata;
  logic [3:0]  m_tkeep, m_tstrb;
  logic        s_tvalid, s_tready, s_tlast;
  logic [31:0] s_tdata;
  logic [3:0]  s_tkeep, s_tstrb;
  logic        busy, err_flag;
  logic [31:0] tx_cnt, rx_cnt, err_cnt;
`ifdef USB_TG_LATENCY_EN
  logic [31:0] lat_cycles;
`endif

  logic        lb, inj, hold_rdy, rand_rdy;
  logic        drv_tvalid, drv_tlast;
  logic [31:0] drv_tdata;
  logic [3:0]  drv_tkeep;

  int n_chk  = 0;
  int n_fail = 0;
  beat_t exp_q[$];

  usb_axis_traffic_gen #(
    .TDATA_WIDTH (W),
    .GAP_CYCLES  (GAP),
    .CNT_WIDTH   (32)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .start         (start),
    .stop          (stop),
    .pkt_len       (pkt_len),
    .pkt_num       (pkt_num),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tkeep  (m_tkeep),
    .m_axis_tstrb  (m_tstrb),
    .m_axis_tlast  (m_tlast),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tdata  (s_tdata),
    .s_axis_tkeep  (s_tkeep),
    .s_axis_tstrb  (s_tstrb),
    .s_axis_tlast  (s_tlast),
    .busy          (busy),
    .tx_pkt_cnt    (tx_cnt),
    .rx_pkt_cnt    (rx_cnt),
    .err_cnt       (err_cnt),
    .err_flag      (err_flag)
`ifdef USB_TG_LATENCY_EN
    ,
    .lat_cycles    (lat_cycles)
`endif
  );

  // Host echo model: loop transmit to receive, optionally corrupting byte 3 of packet 1
  always_comb begin
    s_tvalid = drv_tvalid;
    s_tdata  = drv_tdata;
    s_tkeep  = drv_tkeep;
    s_tlast  = drv_tlast;
    if (lb) begin
      s_tvalid = m_tvalid && m_tready;
      s_tdata  = m_tdata;
      s_tkeep  = m_tkeep;
      s_tlast  = m_tlast;
      if (inj && (m_tdata[7:0] == 8'h01) && !m_tlast) s_tdata = m_tdata ^ 32'h0800_0000;
    end
    s_tstrb = s_tkeep;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference beats straight from the packet rules: byte i of packet p = (p + i) mod 256
  task automatic build_expect(input int len, input int num);
    beat_t b;
    for (int p = 0; p < num; p++) begin
      for (int off = 0; off < len; off += W) begin
        b.data = '0;
        b.keep = '0;
        for (int j = 0; j < W; j++) begin
          if (off + j < len) begin
            b.data[8*j +: 8] = 8'((p + off + j) % 256);
            b.keep[j] = 1'b1;
          end
        end
        b.last = (off + W >= len);
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic run_pkts(input int len, input int prog_num, input int exp_num,
                          input bit rnd, input int exp_err, input int stop_at);
    int leff;
    bit stopped;
    bit done;
    leff    = (len == 0) ? 1 : len;
    stopped = 1'b0;
    done    = 1'b0;
    build_expect(leff, exp_num);
    rand_rdy = rnd;
    @(posedge clk); #1;
    pkt_len = 16'(len);
    pkt_num = 16'(prog_num);
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("tvalid_rise", 64'(m_tvalid), 64'd1);
    check("busy_rise", 64'(busy), 64'd1);
    check("start_clear", {err_cnt, 31'd0, err_flag}, 64'd0);
    for (int c = 0; c < 20000 && !done; c++) begin
      @(negedge clk);
      stop = 1'b0;
      if (!busy) done = 1'b1;
      else if (stop_at >= 0 && !stopped && m_tvalid && !m_tlast && m_tdata[7:0] == 8'(stop_at)) begin
        stop    = 1'b1;
        stopped = 1'b1;
      end
    end
    stop     = 1'b0;
    rand_rdy = 1'b0;
    check("run_done", 64'(done), 64'd1);
    check("tx_cnt", 64'(tx_cnt), 64'(exp_num));
    check("rx_cnt", 64'(rx_cnt), 64'(exp_num));
    check("err_cnt", 64'(err_cnt), 64'(exp_err));
    check("err_flag", 64'(err_flag), 64'(exp_err != 0));
    check("beats_left", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    @(posedge clk); #1;
    drv_tvalid = 1'b1;
    drv_tdata  = d;
    drv_tkeep  = k;
    drv_tlast  = l;
    @(posedge clk); #1;
    drv_tvalid = 1'b0;
  endtask

  // Transmit back-pressure driver
  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_tready = hold_rdy ? 1'b0 : (rand_rdy ? ($urandom_range(0, 1) == 1) : 1'b1);
    end
  end

  // Transmit monitor: beat contents, stall stability, gap length, busy fall after final tlast
  initial begin
    beat_t prev;
    beat_t e;
    logic  prev_stall;
    logic  want_idle;
    int    low_run;
    prev_stall = 1'b0;
    want_idle  = 1'b0;
    low_run    = 0;
    prev       = '{32'd0, 4'd0, 1'b0};
    forever begin
      @(negedge clk);
      if (want_idle) begin
        check("busy_fall", 64'(busy), 64'd0);
        want_idle = 1'b0;
      end
      if (m_tvalid && prev_stall)
        check("stall_hold", 64'({m_tdata, m_tkeep, m_tlast}), 64'({prev.data, prev.keep, prev.last}));
      if (busy && !m_tvalid) begin
        low_run++;
      end else begin
        if (m_tvalid && low_run > 0) check("gap_len", 64'(low_run), 64'(GAP));
        low_run = 0;
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", 64'(m_tdata), 64'hdead_0000_0000);
        end else begin
          e = exp_q.pop_front();
          check("beat", 64'({m_tdata, m_tkeep, m_tstrb, m_tlast}), 64'({e.data, e.keep, e.keep, e.last}));
          if (exp_q.size() == 0) want_idle = 1'b1;
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev       = '{m_tdata, m_tkeep, m_tlast};
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1);
  end

  initial begin
    rstn = 1'b0; start = 1'b0; stop = 1'b0; pkt_len = '0; pkt_num = '0;
    lb = 1'b1; inj = 1'b0; hold_rdy = 1'b0; rand_rdy = 1'b0;
    drv_tvalid = 1'b0; drv_tlast = 1'b0; drv_tdata = '0; drv_tkeep = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_stream", 64'({m_tvalid, m_tdata, m_tkeep, m_tstrb, m_tlast}), 64'd0);
    check("rst_status", 64'({busy, s_tready, err_flag}), 64'd0);
    check("rst_cnts", 64'(tx_cnt | rx_cnt | err_cnt), 64'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    check("tready_high", 64'(s_tready), 64'd1);

    run_pkts(8, 2, 2, 1'b0, 0, -1);
    run_pkts(5, 2, 2, 1'b0, 0, -1);
    run_pkts(1, 3, 3, 1'b0, 0, -1);
    run_pkts(0, 1, 1, 1'b0, 0, -1);

    for (int k = 0; k < 6; k++) begin
      int len;
      int num;
      len = $urandom_range(1, 23);
      num = $urandom_range(1, 4);
      run_pkts(len, num, num, 1'b1, 0, -1);
    end

    inj = 1'b1;
    run_pkts(8, 2, 2, 1'b0, 1, -1);
    inj = 1'b0;
    run_pkts(4, 1, 1, 1'b0, 0, -1);

    run_pkts(8, 0, 4, 1'b0, 0, 3);

    hold_rdy = 1'b1;
    lb       = 1'b0;
    @(posedge clk); #1;
    pkt_len = 16'd8;
    pkt_num = 16'd1;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    send_beat(32'h0302_0100, 4'hF, 1'b1);
    send_beat(32'h0403_0201, 4'hF, 1'b0);
    send_beat(32'h0807_0605, 4'hF, 1'b1);
    check("early_tlast_err", 64'(err_cnt), 64'd1);
    check("early_tlast_rx", 64'(rx_cnt), 64'd2);
    send_beat(32'h0504_0302, 4'hF, 1'b0);
    send_beat(32'h0908_0706, 4'hF, 1'b0);
    check("missing_tlast_err", 64'(err_cnt), 64'd2);
    send_beat(32'h0605_0403, 4'hF, 1'b0);
    send_beat(32'h0a09_0807, 4'hF, 1'b1);
    send_beat(32'h0700_0504, 4'b1011, 1'b1);
    check("hole_err", 64'(err_cnt), 64'd4);
    send_beat(32'h0807_0605, 4'hF, 1'b0);
    send_beat(32'h0c0b_0a09, 4'hF, 1'b1);
    check("resync_clean", 64'(err_cnt), 64'd4);
    send_beat(32'h09f7_07f9, 4'hF, 1'b0);
    send_beat(32'h0d0c_0b0a, 4'hF, 1'b1);
    check("lane_err", 64'(err_cnt), 64'd6);
    check("lane_rx", 64'(rx_cnt), 64'd6);
    check("lane_flag", 64'(err_flag), 64'd1);
    check("stalled_busy", 64'({busy, m_tvalid}), 64'd3);

    @(posedge clk); #1;
    rstn = 1'b0;
    @(negedge clk);
    check("midrst_stream", 64'({m_tvalid, m_tdata, m_tkeep, m_tstrb, m_tlast}), 64'd0);
    check("midrst_status", 64'({busy, s_tready, err_flag}), 64'd0);
    check("midrst_cnts", 64'(tx_cnt | rx_cnt | err_cnt), 64'd0);
    @(posedge clk); #1;
    rstn     = 1'b1;
    hold_rdy = 1'b0;
    lb       = 1'b1;
    repeat (2) @(posedge clk);

    run_pkts(8, 2, 2, 1'b0, 0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
